// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives the request, and the slave (the datapath) returns the status and the result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             v;

  modport master (output start, sub, a, b, input  busy, done, s, c, v);
  modport slave  (input  start, sub, a, b, output busy, done, s, c, v);
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, processed LSB first. One full-adder slice (two half adders and an OR) plus a carry FF.
// Subtraction is computed as A + ~B + 1: the operand is inverted at load time and the carry FF is preset to 1.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  serial_addsub_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-adder slice built from two half adders.
  logic ha1_s, ha1_c, ha2_c, sum_bit, cy_nx;
  assign ha1_s   = a_q[0] ^ b_q[0];
  assign ha1_c   = a_q[0] & b_q[0];
  assign sum_bit = ha1_s ^ cy_q;
  assign ha2_c   = ha1_s & cy_q;
  assign cy_nx   = ha1_c | ha2_c;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    mode_d  = mode_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          cy_d    = bus.sub;
          mode_d  = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = cy_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // cy_q here is the carry into the MSB, which is needed for the signed overflow check.
          state_d = FIN;
          s_d     = {sum_bit, res_q[WIDTH-1:1]};
          c_d     = cy_nx ^ mode_q;
          v_d     = cy_nx ^ cy_q;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      mode_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.c    = c_q;
  assign bus.v    = v_q;
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, parametrised adder/subtractor that processes one bit per clock, LSB first, using a single full-adder slice (two half adders plus an OR gate) and a carry flip-flop. It is the sequential, width-generic successor to the combinational half/full adder cells in the FAFS library. It trades latency for area. A start/busy/done handshake lets a controller or testbench sequence operations.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥ 2.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request an operation; sampled only in IDLE.
- SUB  in  1  0 = A+B, 1 = A−B; sampled with START.
- A  in  WIDTH  operand A; sampled with START.
- B  in  WIDTH  operand B; sampled with START.
- BUSY  out  1  high while an operation is in progress (RUN state).
- DONE  out  1  one-cycle pulse when the result is valid.
- S  out  WIDTH  sum/difference; holds the last result.
- C  out  1  carry out for an add; borrow for a subtract (borrow = NOT carry).
- V  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, FIN. Reset enters IDLE.
- IDLE, START=1: load shift registers with A and with B (or ~B when SUB=1). Set carry FF to SUB. Capture SUB into mode register. Clear bit counter. Go to RUN.
- IDLE, START=0: stay in IDLE.
- RUN, every cycle:
  - Compute sum bit = a0 ^ b0 ^ cy.
  - Compute cy_next = (a0 & b0) | (cy & (a0 ^ b0)).
  - Shift the sum bit into the result shift register MSB. Shift the operand registers right by 1.
  - Increment the counter.
- RUN, counter == WIDTH−1: after that bit is processed, go to FIN and update outputs:
  - S ← assembled result.
  - C ← cy_next XOR mode.
  - V ← cy_next XOR carry into the MSB (the carry FF value when the MSB is processed).
- FIN: DONE=1 for exactly this cycle; go to IDLE unconditionally.
- START in RUN or FIN is ignored and not queued. A, B and SUB changes after the load edge have no effect.
- S, C and V change only on the RUN→FIN transition. They hold their values otherwise, including through later IDLE periods.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

## Timing
- Reset values: state IDLE; BUSY=0, DONE=0, S=0, C=0, V=0; all internal registers 0.
- RST asserted in any state, including mid-RUN: clears everything immediately (asynchronous). The operation is aborted and no DONE is produced.
- START sampled high at edge k (IDLE): BUSY=1 from edge k to edge k+WIDTH.
- Edge k+WIDTH: S, C and V are updated and DONE=1. At edge k+WIDTH+1, DONE returns to 0 and the block is back in IDLE.
- Latency: start edge to DONE is WIDTH cycles. Minimum spacing between accepted STARTs is WIDTH+2 cycles; START held high continuously is accepted every WIDTH+2 cycles.
- BUSY and DONE are never high together. Both are registered outputs.

## Test plan
- WIDTH=8, add: A=0x0F, B=0x01 -> S=0x10, C=0, V=0. DONE is high exactly 8 edges after the START edge, for 1 cycle; BUSY is high for 8 cycles.
- Add wrap-around: A=0xFF, B=0x01 -> S=0x00, C=1, V=0. Signed overflow: A=0x7F, B=0x01 -> S=0x80, C=0, V=1.
- Subtract: SUB=1, A=0x05, B=0x07 -> S=0xFE, C=1 (borrow), V=0. SUB=1, A=0x80, B=0x01 -> S=0x7F, C=0, V=1.
- START pulsed during RUN, with A, B and SUB changed mid-operation: the result matches the originally loaded operands, there is exactly one DONE, and no second operation starts.
- RST asserted for 1 cycle at the 4th RUN cycle of 0x12+0x34 -> outputs 0 immediately, no DONE, block in IDLE. The next START of 0x12+0x34 gives S=0x46.
- WIDTH=16 instance: A=0xFFFF, B=0x0001 -> S=0x0000, C=1; DONE 16 edges after START.
